fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage for the 16-bit pipeline; it is the producer side of the decode stage.
- Owns the PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and presents a registered Instruct/NextPC/InstrValid to decode.
- Accepts a redirect (taken branch or jump, with TruePC) from decode.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- PC_INC, 16'd1, PC increment per fetched word (word-addressed memory).
- BUF_DEPTH, 2, prefetch FIFO entries; a power of two, minimum 2.
- NOP_INSTR, 16'h0000, instruction word driven on Instruct during bubbles.

Ports:
- clk  input  1  Single clock; all state updates on rising edge.
- rst  input  1  Asynchronous, active-low reset.
- Stall  input  1  Decode cannot accept a new instruction; hold the output register.
- Redirect  input  1  Taken branch/jump this cycle.
- TruePC  input  16  Target PC, valid when Redirect=1.
- IMemReq  output  1  Fetch request to instruction memory.
- IMemAddr  output  16  Fetch address; stable while IMemReq=1.
- IMemAck  input  1  Memory accepts the request; IMemData is valid in the same cycle.
- IMemData  input  16  Returned instruction word.
- Instruct  output  16  Instruction to decode.
- NextPC  output  16  Fetch address of Instruct plus PC_INC.
- InstrValid  output  1  Instruct/NextPC hold a real instruction (0 = bubble).

Behaviour:
- Reset (rst=0, async):
  - FetchPC=RESET_PC; FIFO empty; state IDLE.
  - IMemReq=0, IMemAddr=RESET_PC.
  - Instruct=NOP_INSTR, NextPC=16'h0000, InstrValid=0.
- State machine:
  - IDLE: if occupancy<BUF_DEPTH and Redirect=0, go to REQ, driving IMemReq=1, IMemAddr=FetchPC.
  - REQ: IMemReq=1 held until IMemAck; IMemAddr must not change while waiting.
    - On IMemAck without Redirect: push {IMemData, FetchPC+PC_INC}, then FetchPC+=PC_INC.
    - After the push, stay in REQ if space remains after the push; otherwise go to IDLE.
    - Back-to-back acks give one word per cycle.
  - DROP: entered from REQ on Redirect with no IMemAck in the same cycle.
    - IMemReq stays 1 with the old address; a request is never withdrawn.
    - On IMemAck the data is discarded; go to IDLE (or REQ if space).
  - Redirect in REQ with IMemAck in the same cycle: the acked word is discarded; no DROP.
- Redirect (priority over Stall and over any FIFO push):
  - FIFO flushed and FetchPC=TruePC on that edge.
  - Output register loaded with the bubble (NOP_INSTR, InstrValid=0) on that edge.
  - First fetch of TruePC is requested no earlier than the next cycle.
  - Redirect during DROP: FetchPC updates to the newest TruePC; still one ack to drop.
- Output register:
  - Stall=0 and FIFO non-empty: pop the head into Instruct/NextPC, InstrValid=1.
  - Stall=0 and FIFO empty: load the bubble.
  - Stall=1: hold all three outputs; the FIFO keeps filling until full.
- Latency: reset release to first InstrValid=1 is 3 cycles with an immediate ack (request, push, pop).
- Simultaneous push and pop on the same edge is legal at any occupancy, including full.
- FetchPC and NextPC arithmetic is modulo 2^16: 16'hFFFF+1 wraps to 16'h0000, with no error.
- Reset asserted mid-request: IMemReq drops asynchronously; memory must tolerate the abort.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Extra output ports FetchCount[15:0] and SquashCount[15:0], reset to 0, wrapping.
  - FetchCount increments on every IMemAck.
  - SquashCount increments on every discarded ack (in DROP, or same-cycle Redirect+ack) and on every valid FIFO entry flushed by Redirect.
  - The flushed-entry increment is the flushed count, saturating at 16'hFFFF for that update.
- Undefined: these ports and the counter logic do not exist.

Test Plan:
- Reset release, IMemAck always 1, IMemData=address+16'h1000 -> InstrValid rises cycle 3; Instruct 16'h1000,16'h1001,16'h1002 on consecutive cycles; NextPC 1,2,3.
- Stall=1 for 5 cycles after the first instruction -> outputs frozen; IMemReq falls once 2 entries are buffered; after Stall drops, 16'h1001 and 16'h1002 emerge with no gap or duplicate.
- IMemAck delayed 3 cycles with Redirect (TruePC=16'h0040) in the first wait cycle -> old word dropped; next IMemAddr=16'h0040; first valid Instruct=16'h1040 with NextPC=16'h0041.
- Redirect with Stall=1 and a full FIFO -> next cycle InstrValid=0, Instruct=NOP_INSTR; stale entries never appear.
- RESET_PC=16'hFFFE, immediate acks -> addresses FFFE, FFFF, 0000; NextPC FFFF, 0000, 0001.
- FETCH_PERF_EN defined, run the redirect scenario -> SquashCount=1, FetchCount equals the ack count.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Single-outstanding imem req/ack, prefetch FIFO,
// registered decode interface. Define FETCH_PERF_EN to add FetchCount/SquashCount.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] PC_INC    = 16'd1,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [15:0] TruePC,
    output logic        IMemReq,
    output logic [15:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [15:0] IMemData,
    output logic [15:0] Instruct,
    output logic [15:0] NextPC,
    output logic        InstrValid
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] FetchCount,
    output logic [15:0] SquashCount
`endif
);

    localparam int unsigned PC_W  = 16;
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0] instr;
        logic [PC_W-1:0] npc;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_fetch_pc;
    logic              r_req;
    logic [PC_W-1:0]   r_addr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PC_W-1:0]   r_instr;
    logic [PC_W-1:0]   r_npc;
    logic              r_valid;
    fifo_entry_t       r_mem [BUF_DEPTH];

    logic              w_ack;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_next;
    logic [PC_W-1:0]   w_pc_inc;
    fifo_entry_t       w_head;

    assign w_ack        = r_req & IMemAck;
    assign w_push       = (r_state == S_REQ) & w_ack & ~Redirect;
    assign w_pop        = ~Redirect & ~Stall & (r_count != '0);
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_pc_inc     = r_fetch_pc + PC_INC;
    assign w_head       = r_mem[r_rd_ptr];

    // Prefetch storage: data-only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{instr: IMemData, npc: w_pc_inc};
        end
    end

    // FIFO pointers/occupancy; a redirect flushes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (Redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
        end
    end

    // Decode-facing output register: redirect > stall > pop > bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr <= NOP_INSTR;
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else if (Redirect) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!Stall) begin
            if (r_count != '0) begin
                r_instr <= w_head.instr;
                r_npc   <= w_head.npc;
                r_valid <= 1'b1;
            end else begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end
        end
    end

    // Request FSM; a request, once raised, is held until acked (DROP absorbs stale acks).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Redirect) begin
                        r_fetch_pc <= TruePC;
                    end else if (r_count < CNT_W'(BUF_DEPTH)) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_pc;
                    end
                end
                S_REQ: begin
                    if (Redirect) begin
                        r_fetch_pc <= TruePC;
                        if (IMemAck) begin
                            r_addr <= TruePC;
                        end else begin
                            r_state <= S_DROP;
                        end
                    end else if (IMemAck) begin
                        r_fetch_pc <= w_pc_inc;
                        if (w_count_next < CNT_W'(BUF_DEPTH)) begin
                            r_addr <= w_pc_inc;
                        end else begin
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    if (Redirect) r_fetch_pc <= TruePC;
                    // FIFO is empty here, so there is always room to restart.
                    if (IMemAck) begin
                        r_state <= S_REQ;
                        r_addr  <= Redirect ? TruePC : r_fetch_pc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign IMemReq    = r_req;
    assign IMemAddr   = r_addr;
    assign Instruct   = r_instr;
    assign NextPC     = r_npc;
    assign InstrValid = r_valid;

`ifdef FETCH_PERF_EN
    logic [PC_W-1:0] r_fetch_cnt;
    logic [PC_W-1:0] r_squash_cnt;
    logic            w_drop_ack;
    logic [PC_W-1:0] w_flushed;
    logic [PC_W-1:0] w_sq_base;
    logic [PC_W:0]   w_sq_sum;

    assign w_drop_ack = w_ack & (Redirect | (r_state == S_DROP));
    assign w_flushed  = Redirect ? PC_W'(r_count) : '0;
    assign w_sq_base  = r_squash_cnt + PC_W'(w_drop_ack);
    assign w_sq_sum   = {1'b0, w_sq_base} + {1'b0, w_flushed};

    // Flushed-entry update saturates; the single-ack increment wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (w_ack) r_fetch_cnt <= r_fetch_cnt + PC_W'(1);
            r_squash_cnt <= w_sq_sum[PC_W] ? {PC_W{1'b1}} : w_sq_sum[PC_W-1:0];
        end
    end

    assign FetchCount  = r_fetch_cnt;
    assign SquashCount = r_squash_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized stall/redirect/ack traffic checked
// against an instruction-stream model (word at address A carries A+16'h1000).
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] true_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instruct;
    logic [15:0] next_pc;
    logic        instr_valid;

    logic        req2;
    logic [15:0] addr2;
    logic        ack2;
    logic [15:0] data2;
    logic [15:0] instr2;
    logic [15:0] npc2;
    logic        valid2;
    logic        zero_bit;
    logic [15:0] zero_pc;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] squash_count;
    logic [15:0] fetch_count2;
    logic [15:0] squash_count2;
`endif

    int          n_vec;
    int          n_err;
    int          n_acks;
    int          n_valid;
    logic [15:0] exp_pc;
    logic [15:0] m_instr;
    logic [15:0] m_npc;
    logic        m_valid;

    assign ack2     = req2;
    assign data2    = addr2 + 16'h1000;
    assign zero_bit = 1'b0;
    assign zero_pc  = 16'h0000;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .Stall      (stall),
        .Redirect   (redirect),
        .TruePC     (true_pc),
        .IMemReq    (imem_req),
        .IMemAddr   (imem_addr),
        .IMemAck    (imem_ack),
        .IMemData   (imem_data),
        .Instruct   (instruct),
        .NextPC     (next_pc),
        .InstrValid (instr_valid)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount (fetch_count),
        .SquashCount(squash_count)
`endif
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .Stall      (zero_bit),
        .Redirect   (zero_bit),
        .TruePC     (zero_pc),
        .IMemReq    (req2),
        .IMemAddr   (addr2),
        .IMemAck    (ack2),
        .IMemData   (data2),
        .Instruct   (instr2),
        .NextPC     (npc2),
        .InstrValid (valid2)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount (fetch_count2),
        .SquashCount(squash_count2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, then check the results of that edge against the model.
    task automatic run_cycle(input logic st, input logic rd, input logic [15:0] tpc, input logic ack_en);
        logic        req_b;
        logic [15:0] addr_b;
        logic        ackd;
        logic [15:0] e_instr;
        logic [15:0] e_npc;
        req_b    = imem_req;
        addr_b   = imem_addr;
        ackd     = req_b & ack_en;
        stall    = st;
        redirect = rd;
        true_pc  = tpc;
        imem_ack = ackd;
        imem_data = addr_b + 16'h1000;
        if (ackd) n_acks++;
        @(negedge clk);
        if (req_b && !ackd) begin
            check_eq("req_held", 16'(imem_req), 16'h1);
            check_eq("addr_held", imem_addr, addr_b);
        end
        if (rd) begin
            check_eq("redir_valid", 16'(instr_valid), 16'h0);
            check_eq("redir_instr", instruct, NOP);
            m_valid = 1'b0;
            m_instr = NOP;
            exp_pc  = tpc;
        end else if (st) begin
            check_eq("stall_valid", 16'(instr_valid), 16'(m_valid));
            check_eq("stall_instr", instruct, m_instr);
            if (m_valid) check_eq("stall_npc", next_pc, m_npc);
        end else if (instr_valid) begin
            e_instr = exp_pc + 16'h1000;
            e_npc   = exp_pc + 16'd1;
            check_eq("stream_instr", instruct, e_instr);
            check_eq("stream_npc", next_pc, e_npc);
            m_valid = 1'b1;
            m_instr = e_instr;
            m_npc   = e_npc;
            exp_pc  = e_npc;
            n_valid++;
        end else begin
            check_eq("bubble_instr", instruct, NOP);
            m_valid = 1'b0;
            m_instr = NOP;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        stall     = 1'b0;
        redirect  = 1'b0;
        true_pc   = 16'h0000;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        #1;
        check_eq("rst_async_req", 16'(imem_req), 16'h0);
        repeat (2) @(negedge clk);
        check_eq("rst_req", 16'(imem_req), 16'h0);
        check_eq("rst_addr", imem_addr, 16'h0000);
        check_eq("rst_instr", instruct, NOP);
        check_eq("rst_npc", next_pc, 16'h0000);
        check_eq("rst_valid", 16'(instr_valid), 16'h0);
        check_eq("rst_wrap_addr", addr2, 16'hFFFE);
        rst     = 1'b1;
        exp_pc  = 16'h0000;
        m_instr = NOP;
        m_npc   = 16'h0000;
        m_valid = 1'b0;
        n_acks  = 0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        n_valid = 0;
        rst     = 1'b1;
        #2;

        // Latency from reset and the wrap-around instance.
        do_reset();
        run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("lat_c1_valid", 16'(instr_valid), 16'h0);
        check_eq("lat_c1_req", 16'(imem_req), 16'h1);
        check_eq("wrap_addr0", addr2, 16'hFFFE);
        run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("lat_c2_valid", 16'(instr_valid), 16'h0);
        check_eq("wrap_addr1", addr2, 16'hFFFF);
        run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("lat_c3_valid", 16'(instr_valid), 16'h1);
        check_eq("lat_c3_instr", instruct, 16'h1000);
        check_eq("lat_c3_npc", next_pc, 16'h0001);
        check_eq("wrap_addr2", addr2, 16'h0000);
        check_eq("wrap_instr0", instr2, 16'h0FFE);
        check_eq("wrap_npc0", npc2, 16'hFFFF);
        run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("seq_instr1", instruct, 16'h1001);
        check_eq("seq_npc1", next_pc, 16'h0002);
        check_eq("wrap_npc1", npc2, 16'h0000);
        run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("seq_instr2", instruct, 16'h1002);
        check_eq("seq_npc2", next_pc, 16'h0003);
        check_eq("wrap_npc2", npc2, 16'h0001);
`ifdef FETCH_PERF_EN
        check_eq("wrap_fetch_cnt", fetch_count2, 16'd4);
        check_eq("wrap_squash_cnt", squash_count2, 16'd0);
`endif

        // Stall holds outputs while the FIFO fills, then drains without gap or duplicate.
        do_reset();
        repeat (3) run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("stl_first", instruct, 16'h1000);
        repeat (5) run_cycle(1'b1, 1'b0, 16'h0, 1'b1);
        check_eq("stl_frozen", instruct, 16'h1000);
        check_eq("stl_req_off", 16'(imem_req), 16'h0);
        run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("stl_out1", instruct, 16'h1001);
        check_eq("stl_valid1", 16'(instr_valid), 16'h1);
        run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("stl_out2", instruct, 16'h1002);
        check_eq("stl_valid2", 16'(instr_valid), 16'h1);

        // Redirect during an outstanding request; the old word must be dropped.
        do_reset();
        run_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        run_cycle(1'b0, 1'b1, 16'h0040, 1'b0);
        run_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        run_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("drop_req", 16'(imem_req), 16'h1);
        check_eq("drop_next_addr", imem_addr, 16'h0040);
        for (int i = 0; i < 10 && !instr_valid; i++) run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("drop_first_valid", 16'(instr_valid), 16'h1);
        check_eq("drop_first_instr", instruct, 16'h1040);
        check_eq("drop_first_npc", next_pc, 16'h0041);
`ifdef FETCH_PERF_EN
        check_eq("perf_squash", squash_count, 16'd1);
        check_eq("perf_fetch", fetch_count, 16'(n_acks));
`endif

        // Redirect while stalled with a full FIFO: stale entries must never appear.
        do_reset();
        repeat (3) run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        repeat (3) run_cycle(1'b1, 1'b0, 16'h0, 1'b1);
        check_eq("full_req_off", 16'(imem_req), 16'h0);
        run_cycle(1'b1, 1'b1, 16'h0080, 1'b1);
        check_eq("flush_valid", 16'(instr_valid), 16'h0);
        check_eq("flush_instr", instruct, NOP);
        for (int i = 0; i < 12 && !instr_valid; i++) run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("flush_first_instr", instruct, 16'h1080);
        check_eq("flush_first_npc", next_pc, 16'h0081);

        // Randomized traffic against the stream model.
        do_reset();
        n_valid = 0;
        for (int i = 0; i < 2000; i++) begin
            logic        st;
            logic        rd;
            logic        ak;
            logic [15:0] tpc;
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 5);
            ak  = ($urandom_range(0, 99) < 60);
            tpc = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                              : 16'($urandom);
            run_cycle(st, rd, tpc, ak);
        end
        check_eq("rand_liveness", 16'(n_valid > 200), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
